// File: rtl/pendulum_step_driver.sv
// Episode sequencer around one Compute_Single core: owns {thdot, th}, latches actions, launches one step per action.
// Optional stalled-core watchdog: define PENDULUM_WDOG_EN (adds WDOG_CYC and o_wdog).
module pendulum_step_driver #(
    parameter int MAX_STEPS = 200,
    parameter int STEP_W    = 8,
    parameter int GAP_CYC   = 1
`ifdef PENDULUM_WDOG_EN
    ,parameter int WDOG_CYC = 1024
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ep_start,
    output logic              o_ep_ready,
    input  logic [63:0]       i_init_sta,
    input  logic              i_act_valid,
    output logic              o_act_ready,
    input  logic [31:0]       i_act,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [95:0]       o_obs,
    output logic [31:0]       o_rwd,
    output logic              o_done,
    output logic              o_trunc,
    output logic [STEP_W-1:0] o_step,
    output logic              o_cmp_ena,
    output logic [63:0]       o_cmp_sta,
    output logic [31:0]       o_cmp_act,
    input  logic [63:0]       i_cmp_sta,
    input  logic [95:0]       i_cmp_obs,
    input  logic [31:0]       i_cmp_rwd,
    input  logic              i_cmp_done,
`ifdef PENDULUM_WDOG_EN
    output logic              o_wdog,
`endif
    input  logic              i_cmp_valid
);

    typedef enum logic [2:0] {S_IDLE, S_READY, S_RUN, S_GAP, S_OUT} state_t;

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

    state_t            r_state, w_next;
    logic [63:0]       r_sta;
    logic [31:0]       r_act;
    logic [95:0]       r_obs;
    logic [31:0]       r_rwd;
    logic              r_done, r_trunc;
    logic [STEP_W-1:0] r_step;
    logic [GAP_W-1:0]  r_gap_cnt;

    logic w_start, w_act_hs, w_cmp_hit, w_gap_end, w_wdog_to;

    assign o_ep_ready  = (r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_OUT);
    assign o_act_ready = (r_state == S_READY);
    assign o_res_valid = (r_state == S_OUT);
    // Derived from the async-reset state register so reset drops the core enable immediately.
    assign o_cmp_ena   = (r_state == S_RUN);
    assign o_cmp_sta   = r_sta;
    assign o_cmp_act   = r_act;
    assign o_obs       = r_obs;
    assign o_rwd       = r_rwd;
    assign o_done      = r_done;
    assign o_trunc     = r_trunc;
    assign o_step      = r_step;

    assign w_start   = i_ep_start && o_ep_ready;
    assign w_act_hs  = i_act_valid && o_act_ready;
    assign w_cmp_hit = (r_state == S_RUN) && i_cmp_valid;
    assign w_gap_end = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);

`ifdef PENDULUM_WDOG_EN
    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wdog;

    assign w_wdog_to = (r_state == S_RUN) && !i_cmp_valid && (r_wd_cnt == WD_LAST);
    assign o_wdog    = r_wdog;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd_cnt <= '0;
            r_wdog   <= 1'b0;
        end else begin
            r_wdog   <= w_wdog_to;
            r_wd_cnt <= (r_state == S_RUN && !i_cmp_valid) ? r_wd_cnt + WD_W'(1) : '0;
        end
    end
`else
    assign w_wdog_to = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // A restart outranks every other event, including a same-cycle result handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_READY;
            S_READY: begin
                if (w_start)       w_next = S_READY;
                else if (w_act_hs) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_cmp_hit)      w_next = (GAP_CYC == 0) ? S_OUT : S_GAP;
                else if (w_wdog_to) w_next = S_OUT;
            end
            S_GAP:   if (w_gap_end) w_next = S_OUT;
            S_OUT: begin
                if (w_start)          w_next = S_READY;
                else if (i_res_ready) w_next = (r_done || r_trunc) ? S_IDLE : S_READY;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_gap_cnt <= '0;
        else       r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sta   <= '0;
            r_act   <= '0;
            r_obs   <= '0;
            r_rwd   <= '0;
            r_done  <= 1'b0;
            r_trunc <= 1'b0;
            r_step  <= '0;
        end else if (w_start) begin
            r_sta   <= i_init_sta;
            r_step  <= '0;
            r_done  <= 1'b0;
            r_trunc <= 1'b0;
        end else if (w_act_hs) begin
            r_act <= i_act;
        end else if (w_cmp_hit) begin
            r_sta   <= i_cmp_sta;
            r_obs   <= i_cmp_obs;
            r_rwd   <= i_cmp_rwd;
            r_done  <= i_cmp_done;
            r_step  <= (r_step == STEP_MAX) ? r_step : r_step + STEP_W'(1);
            r_trunc <= (r_step + STEP_W'(1)) == STEP_MAX;
        end else if (w_wdog_to) begin
            r_done <= 1'b1;
            r_rwd  <= '0;
        end
    end

endmodule

// File: tb/tb_pendulum_step_driver.sv
// Directed bench for pendulum_step_driver: the bench plays the core and the agent; MAX_STEPS=3, GAP_CYC=1.
module tb_pendulum_step_driver;
    localparam int STEP_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst, i_ep_start, i_act_valid, i_res_ready, i_cmp_done, i_cmp_valid;
    logic [63:0]       i_init_sta, i_cmp_sta;
    logic [31:0]       i_act, i_cmp_rwd;
    logic [95:0]       i_cmp_obs;
    logic              o_ep_ready, o_act_ready, o_res_valid, o_done, o_trunc, o_cmp_ena;
    logic [95:0]       o_obs;
    logic [31:0]       o_rwd, o_cmp_act;
    logic [63:0]       o_cmp_sta;
    logic [STEP_W-1:0] o_step;
`ifdef PENDULUM_WDOG_EN
    logic              o_wdog;
`endif

    pendulum_step_driver #(
        .MAX_STEPS(3), .STEP_W(STEP_W), .GAP_CYC(1)
`ifdef PENDULUM_WDOG_EN
        ,.WDOG_CYC(16)
`endif
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_ep_start(i_ep_start), .o_ep_ready(o_ep_ready), .i_init_sta(i_init_sta),
        .i_act_valid(i_act_valid), .o_act_ready(o_act_ready), .i_act(i_act),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_obs(o_obs), .o_rwd(o_rwd), .o_done(o_done), .o_trunc(o_trunc), .o_step(o_step),
        .o_cmp_ena(o_cmp_ena), .o_cmp_sta(o_cmp_sta), .o_cmp_act(o_cmp_act),
        .i_cmp_sta(i_cmp_sta), .i_cmp_obs(i_cmp_obs), .i_cmp_rwd(i_cmp_rwd),
        .i_cmp_done(i_cmp_done),
`ifdef PENDULUM_WDOG_EN
        .o_wdog(o_wdog),
`endif
        .i_cmp_valid(i_cmp_valid)
    );

    typedef struct {
        logic [31:0]       act;
        logic [63:0]       exp_cmp_sta;
        logic [63:0]       nsta;
        logic [95:0]       obs;
        logic [31:0]       rwd;
        logic              done;
        int                run_cyc;
        int                hold_cyc;
        logic [STEP_W-1:0] exp_step;
        logic              exp_trunc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_ep(input logic [63:0] init);
        i_ep_start = 1'b1;
        i_init_sta = init;
        @(negedge clk);
        i_ep_start = 1'b0;
        chk("start_act_ready", o_act_ready, 1);
        chk("start_cmp_sta", o_cmp_sta, init);
        chk("start_step", o_step, 0);
    endtask

    task automatic wait_act_ready(input string tag);
        int n = 0;
        while (!o_act_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_act_ready_wait"}, o_act_ready, 1);
    endtask

    task automatic do_step(input vec_t v, input string tag, input bit finish);
        wait_act_ready(tag);
        i_act_valid = 1'b1;
        i_act       = v.act;
        @(negedge clk);
        i_act_valid = 1'b0;
        chk({tag, "_launch_ena"}, o_cmp_ena, 1);
        chk({tag, "_cmp_act"}, o_cmp_act, v.act);
        chk({tag, "_cmp_sta"}, o_cmp_sta, v.exp_cmp_sta);
        chk({tag, "_run_act_ready"}, o_act_ready, 0);
        chk({tag, "_run_ep_ready"}, o_ep_ready, 0);
        repeat (v.run_cyc) @(negedge clk);
        chk({tag, "_run_ena_held"}, o_cmp_ena, 1);
        i_cmp_valid = 1'b1;
        i_cmp_sta   = v.nsta;
        i_cmp_obs   = v.obs;
        i_cmp_rwd   = v.rwd;
        i_cmp_done  = v.done;
        @(negedge clk);
        i_cmp_valid = 1'b0;
        i_cmp_sta   = ~v.nsta;
        i_cmp_obs   = ~v.obs;
        i_cmp_rwd   = ~v.rwd;
        i_cmp_done  = ~v.done;
        chk({tag, "_gap_ena"}, o_cmp_ena, 0);
        chk({tag, "_gap_res_valid"}, o_res_valid, 0);
        @(negedge clk);
        chk({tag, "_res_valid"}, o_res_valid, 1);
        chk({tag, "_obs"}, o_obs, v.obs);
        chk({tag, "_rwd"}, o_rwd, v.rwd);
        chk({tag, "_done"}, o_done, v.done);
        chk({tag, "_step"}, o_step, v.exp_step);
        chk({tag, "_trunc"}, o_trunc, v.exp_trunc);
        chk({tag, "_next_sta"}, o_cmp_sta, v.nsta);
        if (v.hold_cyc > 0) begin
            // Stray action and core strobes while the result waits must change nothing.
            i_act_valid = 1'b1;
            i_cmp_valid = 1'b1;
            repeat (v.hold_cyc) @(negedge clk);
            i_act_valid = 1'b0;
            i_cmp_valid = 1'b0;
            chk({tag, "_hold_res_valid"}, o_res_valid, 1);
            chk({tag, "_hold_obs"}, o_obs, v.obs);
            chk({tag, "_hold_rwd"}, o_rwd, v.rwd);
            chk({tag, "_hold_step"}, o_step, v.exp_step);
            chk({tag, "_hold_sta"}, o_cmp_sta, v.nsta);
            chk({tag, "_hold_act_ready"}, o_act_ready, 0);
            chk({tag, "_hold_ena"}, o_cmp_ena, 0);
        end
        if (finish) begin
            i_res_ready = 1'b1;
            @(negedge clk);
            i_res_ready = 1'b0;
            chk({tag, "_res_dropped"}, o_res_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        vec_t vecs[3];
        vec_t v;

        vecs[0] = '{32'h3f3c8151, 64'h3f3b93a1_4049999a, 64'hbf779f2d_c00060ca,
                    96'hbf779f2d_3e9a1b2c_bf7a3c11, 32'hc11a2b3c, 1'b0, 2, 10, 8'd1, 1'b0};
        vecs[1] = '{32'h3d88e6a0, 64'hbf779f2d_c00060ca, 64'hc0123456_c0400000,
                    96'hc0123456_3f000000_bf5db3d7, 32'hc1200000, 1'b0, 0, 0, 8'd2, 1'b0};
        vecs[2] = '{32'hbf000000, 64'hc0123456_c0400000, 64'hc0555555_c0800000,
                    96'hc0555555_bf000000_bf400000, 32'hc1300000, 1'b0, 3, 2, 8'd3, 1'b1};

        i_rst = 1'b1; i_ep_start = 1'b0; i_act_valid = 1'b0; i_res_ready = 1'b0;
        i_cmp_valid = 1'b0; i_cmp_done = 1'b0; i_init_sta = '0; i_cmp_sta = '0;
        i_act = '0; i_cmp_rwd = '0; i_cmp_obs = '0;

        repeat (2) @(negedge clk);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_cmp_ena", o_cmp_ena, 0);
        chk("rst_step", o_step, 0);
        chk("rst_cmp_sta", o_cmp_sta, 0);
        chk("rst_cmp_act", o_cmp_act, 0);
        chk("rst_obs_rwd", {o_obs, o_rwd}, 0);
        chk("rst_flags", {o_done, o_trunc, o_act_ready}, 0);
        chk("rst_ep_ready", o_ep_ready, 1);
        i_rst = 1'b0;
        @(negedge clk);

        // Reset while the core is enabled.
        start_ep(64'h40000000_3f800000);
        i_act_valid = 1'b1;
        i_act       = 32'h40000000;
        @(negedge clk);
        i_act_valid = 1'b0;
        chk("r1_ena_before", o_cmp_ena, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("r1_ena_async_drop", o_cmp_ena, 0);
        chk("r1_cmp_act", o_cmp_act, 0);
        chk("r1_cmp_sta", o_cmp_sta, 0);
        chk("r1_step", o_step, 0);
        @(negedge clk);
        i_rst = 1'b0;
        i_cmp_valid = 1'b1;
        i_cmp_sta = 64'h11111111_22222222;
        i_cmp_obs = 96'h33333333_44444444_55555555;
        i_cmp_rwd = 32'h66666666;
        repeat (3) @(negedge clk);
        i_cmp_valid = 1'b0;
        chk("r1_late_valid_res", o_res_valid, 0);
        chk("r1_late_valid_obs", o_obs, 0);
        chk("r1_late_valid_sta", o_cmp_sta, 0);
        chk("r1_idle_act_ready", o_act_ready, 0);
        chk("r1_idle_ep_ready", o_ep_ready, 1);

        // Three-step episode: basic step, closed loop, back-pressure, truncation.
        start_ep(64'h3f3b93a1_4049999a);
        for (int i = 0; i < 3; i++) begin
            do_step(vecs[i], $sformatf("ep1_s%0d", i), 1'b1);
        end
        chk("trunc_idle_act_ready", o_act_ready, 0);
        chk("trunc_idle_ep_ready", o_ep_ready, 1);
        chk("trunc_idle_ena", o_cmp_ena, 0);

        // Restart wins over a same-cycle result handshake.
        start_ep(64'h3e000000_3f000000);
        v = '{32'h3f800000, 64'h3e000000_3f000000, 64'h3e100000_3f100000,
              96'h3e100000_3f5f0000_3f000000, 32'hbf800000, 1'b0, 1, 0, 8'd1, 1'b0};
        do_step(v, "ep2_s0", 1'b0);
        i_ep_start  = 1'b1;
        i_res_ready = 1'b1;
        i_init_sta  = 64'h3d000000_bd000000;
        @(negedge clk);
        i_ep_start  = 1'b0;
        i_res_ready = 1'b0;
        chk("restart_act_ready", o_act_ready, 1);
        chk("restart_step", o_step, 0);
        chk("restart_res_valid", o_res_valid, 0);
        chk("restart_cmp_sta", o_cmp_sta, 64'h3d000000_bd000000);

        // Core done ends the episode after the handshake.
        v = '{32'hc0000000, 64'h3d000000_bd000000, 64'h3d200000_bd200000,
              96'h3d200000_bd1fff00_3f7fff00, 32'hc0a00000, 1'b1, 0, 0, 8'd1, 1'b0};
        do_step(v, "ep3_done", 1'b1);
        chk("done_idle_act_ready", o_act_ready, 0);
        chk("done_idle_ep_ready", o_ep_ready, 1);

`ifdef PENDULUM_WDOG_EN
        begin
            int n_ena = 0;
            int n = 0;
            start_ep(64'h3c000000_3c800000);
            i_act_valid = 1'b1;
            i_act       = 32'h3f000000;
            @(negedge clk);
            i_act_valid = 1'b0;
            while (!o_wdog && n < 40) begin
                if (o_cmp_ena) n_ena++;
                @(negedge clk);
                n++;
            end
            chk("wdog_pulse", o_wdog, 1);
            chk("wdog_run_cycles", n_ena, 16);
            chk("wdog_ena", o_cmp_ena, 0);
            chk("wdog_res_valid", o_res_valid, 1);
            chk("wdog_done", o_done, 1);
            chk("wdog_rwd", o_rwd, 0);
            chk("wdog_sta", o_cmp_sta, 64'h3c000000_3c800000);
            @(negedge clk);
            chk("wdog_pulse_end", o_wdog, 0);
            chk("wdog_res_held", o_res_valid, 1);
            i_res_ready = 1'b1;
            @(negedge clk);
            i_res_ready = 1'b0;
            chk("wdog_idle", o_act_ready, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
